// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM states, vector
// geometry and the reference truth table of F1 = A'B' + AD' + BC'D'.
package sweep_pkg;

    localparam int N_VEC = 16;
    localparam int VEC_W = 4;

    // Bit i is F1 evaluated at abcd = i.
    localparam logic [N_VEC-1:0] F1_GOLDEN = 16'h551F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_e;

    // True when idx addresses the final vector of a sweep.
    function automatic logic isLastVec(input logic [VEC_W-1:0] idx);
        return idx == VEC_W'(N_VEC - 1);
    endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle timer: loaded with a cycle count, counts down while enabled and
// pulses expired in the last enabled cycle of the loaded window.
module sweep_settle_timer
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [VEC_W-1:0] count_i,
    output logic             expired_o
);

    logic [VEC_W-1:0] cnt_q;
    logic [VEC_W-1:0] cnt_d;

    // Reload takes priority over counting; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = count_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - VEC_W'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q == VEC_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all 16 abcd vectors, waits SETTLE_CYCLES per
// vector, captures two function outputs and flags the first disagreement.
// Optional golden compare of the captured F1 table: SWEEP_GOLDEN_CHECK_EN.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
`ifdef SWEEP_GOLDEN_CHECK_EN
    ,
    parameter logic [N_VEC-1:0] GOLDEN_F1 = F1_GOLDEN
`endif
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] abcd,
    input  logic             f1_in,
    input  logic             f2_in,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] tt_f1,
    output logic [N_VEC-1:0] tt_f2,
    output logic             mismatch,
    output logic [VEC_W-1:0] mismatch_idx
`ifdef SWEEP_GOLDEN_CHECK_EN
    ,
    output logic             golden_fail
`endif
);

    localparam logic [VEC_W-1:0] SETTLE_LOAD = VEC_W'(SETTLE_CYCLES);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] idx_q, idx_d;
    logic [N_VEC-1:0] ttF1_q, ttF1_d;
    logic [N_VEC-1:0] ttF2_q, ttF2_d;
    logic             mismatch_q, mismatch_d;
    logic [VEC_W-1:0] mismatchIdx_q, mismatchIdx_d;
    logic             timerLoad;
    logic             timerEn;
    logic             timerExpired;
`ifdef SWEEP_GOLDEN_CHECK_EN
    logic             goldenFail_q, goldenFail_d;
`endif

    sweep_settle_timer u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (timerLoad),
        .en_i      (timerEn),
        .count_i   (SETTLE_LOAD),
        .expired_o (timerExpired)
    );

    // Sweep sequencing, capture and first-mismatch tracking.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        ttF1_d        = ttF1_q;
        ttF2_d        = ttF2_q;
        mismatch_d    = mismatch_q;
        mismatchIdx_d = mismatchIdx_q;
`ifdef SWEEP_GOLDEN_CHECK_EN
        goldenFail_d  = goldenFail_q;
`endif
        timerLoad     = 1'b0;
        timerEn       = 1'b0;
        abcd          = '0;
        busy          = 1'b0;
        done          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d         = '0;
                    ttF1_d        = '0;
                    ttF2_d        = '0;
                    mismatch_d    = 1'b0;
                    mismatchIdx_d = '0;
`ifdef SWEEP_GOLDEN_CHECK_EN
                    goldenFail_d  = 1'b0;
`endif
                    timerLoad     = 1'b1;
                    state_d       = SETTLE;
                end
            end

            SETTLE: begin
                abcd    = idx_q;
                busy    = 1'b1;
                timerEn = 1'b1;
                if (timerExpired) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                abcd          = idx_q;
                busy          = 1'b1;
                ttF1_d[idx_q] = f1_in;
                ttF2_d[idx_q] = f2_in;
                if ((f1_in != f2_in) && !mismatch_q) begin
                    mismatch_d    = 1'b1;
                    mismatchIdx_d = idx_q;
                end
                if (isLastVec(idx_q)) begin
                    // Compare against the table including this final write
                    // so the verdict is visible during the DONE cycle.
`ifdef SWEEP_GOLDEN_CHECK_EN
                    goldenFail_d = (ttF1_d != GOLDEN_F1);
`endif
                    state_d = DONE;
                end else begin
                    idx_d     = idx_q + VEC_W'(1);
                    timerLoad = 1'b1;
                    state_d   = SETTLE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            ttF1_q        <= '0;
            ttF2_q        <= '0;
            mismatch_q    <= 1'b0;
            mismatchIdx_q <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            ttF1_q        <= ttF1_d;
            ttF2_q        <= ttF2_d;
            mismatch_q    <= mismatch_d;
            mismatchIdx_q <= mismatchIdx_d;
        end
    end

`ifdef SWEEP_GOLDEN_CHECK_EN
    // Golden verdict register, held until the next accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            goldenFail_q <= 1'b0;
        end else begin
            goldenFail_q <= goldenFail_d;
        end
    end

    assign golden_fail = goldenFail_q;
`endif

    assign tt_f1        = ttF1_q;
    assign tt_f2        = ttF2_q;
    assign mismatch     = mismatch_q;
    assign mismatch_idx = mismatchIdx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Testbench for truth_table_sweeper: two instances (SETTLE_CYCLES 2 and 1),
// behavioural F1 model driving the inputs, per-sweep expectation queue.
module tb_truth_table_sweeper;

    typedef struct {
        int          latency;
        logic [15:0] tt1;
        logic [15:0] tt2;
        logic        mm;
        logic [3:0]  mmIdx;
        logic        golden;
    } exp_t;

    exp_t sbQ[$];

    int checks = 0;
    int passes = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic startDrv = 1'b0;
    logic sweepSel = 1'b0;
    int   f1Mode = 0;
    logic [15:0] f2FlipMask = 16'h0000;

    logic start0, start1;
    logic [3:0] abcd0, abcd1;
    logic f1In0, f2In0, f1In1, f2In1;
    logic busy0, busy1, done0, done1;
    logic [15:0] tt1_0, tt2_0, tt1_1, tt2_1;
    logic mm0, mm1;
    logic [3:0] mmIdx0, mmIdx1;
    logic golden0, golden1;

    logic curDone, curBusy, curMm;
    logic [3:0] curAbcd, curMmIdx;
    logic [15:0] curTt1, curTt2;
    logic curGolden;

    always #5 clk = ~clk;

    function automatic logic f1Model(input logic [3:0] v);
        logic a, b, c, d;
        a = v[3];
        b = v[2];
        c = v[1];
        d = v[0];
        return (!a && !b) || (a && !d) || (b && !c && !d);
    endfunction

    assign start0 = startDrv & ~sweepSel;
    assign start1 = startDrv & sweepSel;
    assign f1In0  = (f1Mode == 0) ? f1Model(abcd0) : (f1Mode == 1);
    assign f2In0  = f1Model(abcd0) ^ f2FlipMask[abcd0];
    assign f1In1  = 1'b1;
    assign f2In1  = 1'b0;

    assign curDone  = sweepSel ? done1  : done0;
    assign curBusy  = sweepSel ? busy1  : busy0;
    assign curAbcd  = sweepSel ? abcd1  : abcd0;
    assign curTt1   = sweepSel ? tt1_1  : tt1_0;
    assign curTt2   = sweepSel ? tt2_1  : tt2_0;
    assign curMm    = sweepSel ? mm1    : mm0;
    assign curMmIdx = sweepSel ? mmIdx1 : mmIdx0;
`ifdef SWEEP_GOLDEN_CHECK_EN
    assign curGolden = sweepSel ? golden1 : golden0;
`else
    assign golden0   = 1'b0;
    assign golden1   = 1'b0;
    assign curGolden = 1'b0;
`endif

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start0),
        .abcd         (abcd0),
        .f1_in        (f1In0),
        .f2_in        (f2In0),
        .busy         (busy0),
        .done         (done0),
        .tt_f1        (tt1_0),
        .tt_f2        (tt2_0),
        .mismatch     (mm0),
        .mismatch_idx (mmIdx0)
`ifdef SWEEP_GOLDEN_CHECK_EN
        ,
        .golden_fail  (golden0)
`endif
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start1),
        .abcd         (abcd1),
        .f1_in        (f1In1),
        .f2_in        (f2In1),
        .busy         (busy1),
        .done         (done1),
        .tt_f1        (tt1_1),
        .tt_f2        (tt2_1),
        .mismatch     (mm1),
        .mismatch_idx (mmIdx1)
`ifdef SWEEP_GOLDEN_CHECK_EN
        ,
        .golden_fail  (golden1)
`endif
    );

    // Builds the expected sweep result from the current stimulus setup.
    task automatic pushExpected();
        exp_t e;
        logic b1, b2;
        e.mm = 1'b0;
        e.mmIdx = 4'd0;
        e.tt1 = 16'h0000;
        e.tt2 = 16'h0000;
        e.latency = sweepSel ? 16 * 2 : 16 * 3;
        for (int i = 0; i < 16; i++) begin
            if (sweepSel) begin
                b1 = 1'b1;
                b2 = 1'b0;
            end else begin
                b1 = (f1Mode == 0) ? f1Model(4'(i)) : (f1Mode == 1);
                b2 = f1Model(4'(i)) ^ f2FlipMask[i];
            end
            e.tt1[i] = b1;
            e.tt2[i] = b2;
            if ((b1 != b2) && !e.mm) begin
                e.mm = 1'b1;
                e.mmIdx = 4'(i);
            end
        end
        e.golden = (e.tt1 != 16'h551F);
        sbQ.push_back(e);
    endtask

    // Pulses start for one cycle; returns at the negedge after acceptance.
    task automatic startSweep(input bit push);
        if (push) pushExpected();
        @(negedge clk);
        startDrv = 1'b1;
        @(posedge clk);
        @(negedge clk);
        startDrv = 1'b0;
    endtask

    // Waits for done, optionally re-pulsing start, and checks the results.
    task automatic finishSweep(input string name, input int rePulseAt, input bit pulseInDone);
        int edges;
        exp_t e;
        edges = 0;
        while (curDone !== 1'b1 && edges < 200) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == rePulseAt) startDrv = 1'b1;
            else if (edges == rePulseAt + 1) startDrv = 1'b0;
        end
        checks++;
        if (curDone !== 1'b1) begin
            $display("[TB] FAIL %s done_timeout: done=%b after %0d edges", name, curDone, edges);
            startDrv = 1'b0;
            if (sbQ.size() > 0) void'(sbQ.pop_front());
            return;
        end
        passes++;
        if (pulseInDone) startDrv = 1'b1;
        e = sbQ.pop_front();
        checks++;
        if (edges !== e.latency) $display("[TB] FAIL %s latency: got %0d edges, want %0d", name, edges, e.latency);
        else passes++;
        checks++;
        if (curTt1 !== e.tt1) $display("[TB] FAIL %s tt_f1: got %h, want %h", name, curTt1, e.tt1);
        else passes++;
        checks++;
        if (curTt2 !== e.tt2) $display("[TB] FAIL %s tt_f2: got %h, want %h", name, curTt2, e.tt2);
        else passes++;
        checks++;
        if (curMm !== e.mm) $display("[TB] FAIL %s mismatch: got %b, want %b", name, curMm, e.mm);
        else passes++;
        checks++;
        if (curMmIdx !== e.mmIdx) $display("[TB] FAIL %s mismatch_idx: got %0d, want %0d", name, curMmIdx, e.mmIdx);
        else passes++;
        checks++;
        if (curBusy !== 1'b0 || curAbcd !== 4'd0) $display("[TB] FAIL %s done_outputs: busy=%b abcd=%0d, want 0/0", name, curBusy, curAbcd);
        else passes++;
`ifdef SWEEP_GOLDEN_CHECK_EN
        checks++;
        if (curGolden !== e.golden) $display("[TB] FAIL %s golden_fail: got %b, want %b", name, curGolden, e.golden);
        else passes++;
`endif
        @(negedge clk);
        startDrv = 1'b0;
        checks++;
        if (curDone !== 1'b0 || curBusy !== 1'b0 || curAbcd !== 4'd0)
            $display("[TB] FAIL %s after_done: done=%b busy=%b abcd=%0d, want 0/0/0", name, curDone, curBusy, curAbcd);
        else passes++;
        checks++;
        if (curTt1 !== e.tt1 || curMmIdx !== e.mmIdx) $display("[TB] FAIL %s results_held: tt_f1=%h idx=%0d, want %h/%0d", name, curTt1, curMmIdx, e.tt1, e.mmIdx);
        else passes++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || abcd0 !== 4'd0)
            $display("[TB] FAIL reset_ctrl: busy=%b done=%b abcd=%0d, want 0/0/0", busy0, done0, abcd0);
        else passes++;
        checks++;
        if (tt1_0 !== 16'h0 || tt2_0 !== 16'h0 || mm0 !== 1'b0 || mmIdx0 !== 4'd0)
            $display("[TB] FAIL reset_results: tt1=%h tt2=%h mm=%b idx=%0d, want zeros", tt1_0, tt2_0, mm0, mmIdx0);
        else passes++;
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || tt1_1 !== 16'h0 || golden0 !== 1'b0)
            $display("[TB] FAIL reset_dut1: busy=%b done=%b tt1=%h golden=%b, want zeros", busy1, done1, tt1_1, golden0);
        else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_model_sweep();
        sweepSel = 1'b0;
        f1Mode = 0;
        f2FlipMask = 16'h0000;
        startSweep(1'b1);
        finishSweep("model", -10, 1'b0);
    endtask

    task automatic test_mismatch();
        f2FlipMask = 16'h0020;
        startSweep(1'b1);
        finishSweep("flip5", -10, 1'b0);
        f2FlipMask = 16'h0220;
        startSweep(1'b1);
        finishSweep("flip5_9", -10, 1'b0);
        f2FlipMask = 16'h0000;
    endtask

    task automatic test_back_to_back();
        startSweep(1'b1);
        finishSweep("restart_ignored", 10, 1'b1);
        startSweep(1'b1);
        checks++;
        if (busy0 !== 1'b1 || abcd0 !== 4'd0) $display("[TB] FAIL new_sweep_start: busy=%b abcd=%0d, want 1/0", busy0, abcd0);
        else passes++;
        checks++;
        if (tt1_0 !== 16'h0 || tt2_0 !== 16'h0 || mm0 !== 1'b0) $display("[TB] FAIL new_sweep_clear: tt1=%h tt2=%h mm=%b, want zeros", tt1_0, tt2_0, mm0);
        else passes++;
        finishSweep("new_sweep", -10, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        int waitCnt;
        bit sawDone;
        f2FlipMask = 16'h0001;
        startSweep(1'b0);
        waitCnt = 0;
        while (abcd0 !== 4'd7 && waitCnt < 100) begin
            @(negedge clk);
            waitCnt++;
        end
        checks++;
        if (abcd0 !== 4'd7) $display("[TB] FAIL reach_vec7: abcd=%0d, want 7", abcd0);
        else passes++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy0 !== 1'b0 || abcd0 !== 4'd0 || done0 !== 1'b0) $display("[TB] FAIL midreset_ctrl: busy=%b abcd=%0d done=%b, want 0/0/0", busy0, abcd0, done0);
        else passes++;
        checks++;
        if (tt1_0 !== 16'h0 || tt2_0 !== 16'h0 || mm0 !== 1'b0) $display("[TB] FAIL midreset_results: tt1=%h tt2=%h mm=%b, want zeros", tt1_0, tt2_0, mm0);
        else passes++;
        sawDone = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) sawDone = 1'b1;
        end
        checks++;
        if (sawDone) $display("[TB] FAIL midreset_no_done: activity seen=%b, want 0", sawDone);
        else passes++;
        f2FlipMask = 16'h0000;
        startSweep(1'b1);
        finishSweep("after_reset", -10, 1'b0);
    endtask

    task automatic test_settle_one();
        sweepSel = 1'b1;
        startSweep(1'b1);
        finishSweep("settle1", -10, 1'b0);
        sweepSel = 1'b0;
    endtask

    task automatic test_golden();
`ifdef SWEEP_GOLDEN_CHECK_EN
        sweepSel = 1'b0;
        f1Mode = 2;
        startSweep(1'b1);
        finishSweep("golden_stuck0", -10, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (golden0 !== 1'b1) $display("[TB] FAIL golden_hold: got %b, want 1", golden0);
        else passes++;
        f1Mode = 0;
        startSweep(1'b1);
        checks++;
        if (golden0 !== 1'b0) $display("[TB] FAIL golden_clear: got %b, want 0", golden0);
        else passes++;
        finishSweep("golden_ok", -10, 1'b0);
`endif
    endtask

    initial begin
        $display("[TB] truth_table_sweeper bench starting");
        test_reset();
        test_model_sweep();
        test_mismatch();
        test_back_to_back();
        test_reset_mid_sweep();
        test_settle_one();
        test_golden();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
